// File: rtl/sync_fifo.sv
// Single-clock FIFO with an exact occupancy counter, programmable almost flags,
// sticky overflow/underflow and a compile-time registered-read / FWFT output.
module sync_fifo #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_LEVEL  = 12,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] w_data,
  input  logic                 w_en,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic                 w_overflow,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic                 r_underflow,
  output logic [ADDR_SIZE:0]   count
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] w_ptr;
  logic [ADDR_SIZE-1:0] r_ptr;
  logic [CW-1:0]        count_q;
  logic                 wr_acc;
  logic                 rd_acc;

  // Status flags decode the count register only, so they never glitch on inputs.
  assign w_full         = (count_q == CW'(DEPTH));
  assign r_empty        = (count_q == '0);
  assign w_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign r_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count          = count_q;

  // Acceptance looks only at start-of-cycle state; a same-cycle read never frees a full slot.
  assign wr_acc = w_en && !w_full;
  assign rd_acc = r_en && !r_empty;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[w_ptr] <= w_data;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_q     <= '0;
      w_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + ADDR_SIZE'(1);
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + ADDR_SIZE'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (w_en && w_full) begin
        w_overflow <= 1'b1;
      end
      if (r_en && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign r_data = mem[r_ptr];
  end else begin : g_reg_read
    logic [DATA_SIZE-1:0] r_data_q;

    // Output register only moves on an accepted read.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q <= '0;
      end else if (rd_acc) begin
        r_data_q <= mem[r_ptr];
      end
    end

    assign r_data = r_data_q;
  end

endmodule
